// File: rtl/ro_freq_counter.sv
// ro_freq_counter: gated rising-edge counter for the ring-oscillator array.
// Counts synchronized ro_in edges over a programmable wb_clk_i window.
module ro_freq_counter #(
   parameter int CNT_W         = 24,
   parameter int GATE_W        = 24,
   parameter int SETTLE_CYCLES = 16,
   parameter int SYNC_STAGES   = 2
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_ni,
   input  logic              ro_in,
   input  logic              meas_start_i,
   input  logic              abort_i,
   input  logic [GATE_W-1:0] gate_cycles_i,
   output logic              ro_en_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [CNT_W-1:0]  count_o,
   output logic              ovf_o
);

   localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SET_W-1:0] SET_LD = SET_W'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_d;
   logic                   edge_det;
   logic                   active;
   logic [SET_W-1:0]       set_cnt;
   logic [GATE_W-1:0]      gate_m1;
   logic [GATE_W-1:0]      gate_cnt;
   logic [CNT_W-1:0]       edge_cnt;
   logic [CNT_W-1:0]       cnt_nxt;
   logic                   ovf;
   logic                   ovf_nxt;

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         sync_q <= '0;
         sync_d <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], ro_in};
         sync_d <= sync_q[SYNC_STAGES-1];
      end
   end

   assign edge_det = sync_q[SYNC_STAGES-1] & ~sync_d;

   // Saturating count; overflow marks an edge lost at all-ones.
   always_comb begin
      cnt_nxt = edge_cnt;
      ovf_nxt = ovf;
      if (edge_det) begin
         if (&edge_cnt) ovf_nxt = 1'b1;
         else cnt_nxt = edge_cnt + CNT_W'(1);
      end
   end

   assign ro_en_o = active;
   assign busy_o  = active;

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state    <= IDLE;
         active   <= 1'b0;
         set_cnt  <= '0;
         gate_m1  <= '0;
         gate_cnt <= '0;
         edge_cnt <= '0;
         ovf      <= 1'b0;
         done_o   <= 1'b0;
         count_o  <= '0;
         ovf_o    <= 1'b0;
      end else begin
         done_o <= 1'b0;
         unique case (state)
            IDLE: begin
               if (meas_start_i && !abort_i) begin
                  state   <= SETTLE;
                  active  <= 1'b1;
                  set_cnt <= SET_LD;
                  gate_m1 <= (gate_cycles_i == '0) ? '0
                           : gate_cycles_i - GATE_W'(1);
               end
            end
            SETTLE: begin
               if (abort_i) begin
                  state  <= IDLE;
                  active <= 1'b0;
               end else if (set_cnt == '0) begin
                  state    <= MEASURE;
                  edge_cnt <= '0;
                  ovf      <= 1'b0;
                  gate_cnt <= gate_m1;
               end else begin
                  set_cnt <= set_cnt - SET_W'(1);
               end
            end
            MEASURE: begin
               if (abort_i) begin
                  state  <= IDLE;
                  active <= 1'b0;
               end else begin
                  edge_cnt <= cnt_nxt;
                  ovf      <= ovf_nxt;
                  if (gate_cnt == '0) begin
                     state   <= DONE;
                     active  <= 1'b0;
                     done_o  <= 1'b1;
                     count_o <= cnt_nxt;
                     ovf_o   <= ovf_nxt;
                  end else begin
                     gate_cnt <= gate_cnt - GATE_W'(1);
                  end
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ro_freq_counter.sv
// tb_ro_freq_counter: window-arithmetic model plus directed scenarios
// for the gated ring-oscillator frequency counter.
module tb_ro_freq_counter;

   localparam int S    = 16;
   localparam int SYNC = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ro_in = 1'b0;
   logic        meas_start = 1'b0;
   logic        abort = 1'b0;
   logic [23:0] gate = '0;

   logic        ro_en_a, busy_a, done_a, ovf_a;
   logic [23:0] cnt_a;
   logic        ro_en_b, busy_b, done_b, ovf_b;
   logic [7:0]  cnt_b;

   int checks = 0;
   int errors = 0;
   int ecount = 0;
   int n_done = 0;
   int ro_per = 0;
   logic ro_lvl = 1'b0;
   int rises[$];

   // model state
   bit m_act = 0;
   int m_k = 0;
   int m_g = 1;
   bit exp_busy = 0;
   bit exp_done = 0;
   int exp_c24 = 0;
   bit exp_o24 = 0;
   int exp_c8 = 0;
   bit exp_o8 = 0;

   ro_freq_counter dut_a (
      .wb_clk_i(clk), .wb_rst_ni(rst_n), .ro_in(ro_in),
      .meas_start_i(meas_start), .abort_i(abort),
      .gate_cycles_i(gate), .ro_en_o(ro_en_a), .busy_o(busy_a),
      .done_o(done_a), .count_o(cnt_a), .ovf_o(ovf_a)
   );

   ro_freq_counter #(.CNT_W(8)) dut_b (
      .wb_clk_i(clk), .wb_rst_ni(rst_n), .ro_in(ro_in),
      .meas_start_i(meas_start), .abort_i(abort),
      .gate_cycles_i(gate), .ro_en_o(ro_en_b), .busy_o(busy_b),
      .done_o(done_b), .count_o(cnt_b), .ovf_o(ovf_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // rises whose synchronized edge lands inside edge-interval [lo,hi]
   function automatic int win_count(input int lo, input int hi);
      int c;
      c = 0;
      foreach (rises[i])
         if (rises[i] + SYNC >= lo && rises[i] + SYNC <= hi) c++;
      return c;
   endfunction

   // ecount = number of the most recent posedge, settled 1 unit after it
   initial forever begin
      @(posedge clk);
      #1 ecount++;
   end

   initial begin
      int ph;
      ph = 0;
      forever begin
         @(posedge clk);
         #2;
         if (ro_per == 0) ro_in = ro_lvl;
         else begin
            ph = (ph + 1) % ro_per;
            ro_in = (ph < ro_per / 2);
         end
      end
   end

   initial forever begin
      @(posedge ro_in);
      rises.push_back(ecount);
   end

   initial begin
      int e, lst, raw;
      bit bsy, dn;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_act = 0; exp_busy = 0; exp_done = 0;
            exp_c24 = 0; exp_o24 = 0; exp_c8 = 0; exp_o8 = 0;
         end else begin
            e   = ecount + 1;
            lst = m_k + S + m_g;
            bsy = m_act && (e - 1 >= m_k) && (e - 1 < lst);
            dn  = m_act && (e - 1 == lst);
            exp_done = 0;
            if (bsy && abort) begin
               m_act = 0;
               exp_busy = 0;
            end else if (bsy && e == lst) begin
               raw = win_count(m_k + S, lst - 1);
               exp_c24 = (raw > 24'hFFFFFF) ? 24'hFFFFFF : raw;
               exp_o24 = (raw > 24'hFFFFFF);
               exp_c8  = (raw > 255) ? 255 : raw;
               exp_o8  = (raw > 255);
               exp_done = 1;
               exp_busy = 0;
            end else if (bsy) begin
               exp_busy = 1;
            end else begin
               if (dn) m_act = 0;
               exp_busy = 0;
               if (!dn && meas_start && !abort) begin
                  m_act = 1;
                  m_k = e;
                  m_g = (gate == 0) ? 1 : int'(gate);
                  exp_busy = 1;
               end
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (done_a) n_done++;
      chk("busy_a", busy_a, exp_busy);
      chk("ro_en_a", ro_en_a, exp_busy);
      chk("done_a", done_a, exp_done);
      chk("count_a", cnt_a, exp_c24);
      chk("ovf_a", ovf_a, exp_o24);
      chk("busy_b", busy_b, exp_busy);
      chk("done_b", done_b, exp_done);
      chk("count_b", cnt_b, exp_c8);
      chk("ovf_b", ovf_b, exp_o8);
   end

   task automatic start(input int g, output int k);
      @(negedge clk);
      gate = 24'(g);
      meas_start = 1'b1;
      k = ecount + 1;
      @(negedge clk);
      meas_start = 1'b0;
      gate = 24'($urandom_range(1, 9));
   endtask

   task automatic wait_done(input string nm, input int maxc, output int at);
      at = -1;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk);
         if (done_a) begin
            at = ecount;
            break;
         end
      end
      if (at < 0) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no done expected done within %0d",
                  nm, maxc);
      end
   endtask

   initial begin
      int k, k2, at, nd;
      repeat (3) @(negedge clk);
      chk("rst_ro_en", ro_en_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_count", cnt_a, 0);
      chk("rst_ovf", ovf_a, 0);
      rst_n = 1'b1;
      ro_per = 4;
      repeat (20) @(negedge clk);

      // nominal: period 4, G=100
      start(100, k);
      wait_done("nom", 300, at);
      chk("nom_done_cycle", at - k + 1, 117);
      chk("nom_count", cnt_a, 25);
      chk("nom_ovf", ovf_a, 0);
      repeat (3) @(negedge clk);

      // abort 50 cycles into MEASURE
      start(500, k);
      repeat (S + 50) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", busy_a, 0);
      chk("abort_ro_en", ro_en_a, 0);
      nd = n_done;
      repeat (600) @(negedge clk);
      chk("abort_no_done", n_done - nd, 0);
      chk("abort_count_kept", cnt_a, 25);

      // abort and start together in IDLE
      @(negedge clk);
      meas_start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      meas_start = 1'b0;
      abort = 1'b0;
      chk("abort_beats_start", busy_a, 0);
      repeat (3) @(negedge clk);

      // ignored start mid-MEASURE, then back-to-back restart
      nd = n_done;
      start(100, k);
      repeat (S + 40) @(negedge clk);
      meas_start = 1'b1;
      gate = 24'd7;
      @(negedge clk);
      meas_start = 1'b0;
      wait_done("ign", 300, at);
      chk("ign_done_cycle", at - k + 1, 117);
      chk("ign_count", cnt_a, 25);
      meas_start = 1'b1;
      gate = 24'd5;
      @(negedge clk);
      chk("start_in_done_ignored", busy_a, 0);
      k2 = ecount + 1;
      @(negedge clk);
      meas_start = 1'b0;
      chk("start_after_done", busy_a, 1);
      wait_done("b2b", 60, at);
      chk("b2b_done_cycle", at - k2 + 1, S + 5 + 1);
      repeat (3) @(negedge clk);
      chk("ign_done_pulses", n_done - nd, 2);

      // saturation: period 2, G=1000
      ro_per = 2;
      repeat (10) @(negedge clk);
      nd = n_done;
      start(1000, k);
      wait_done("sat", 1100, at);
      chk("sat_done_cycle", at - k + 1, 1017);
      chk("sat_count8", cnt_b, 255);
      chk("sat_ovf8", ovf_b, 1);
      chk("sat_count24", cnt_a, 500);
      chk("sat_ovf24", ovf_a, 0);
      repeat (3) @(negedge clk);
      chk("sat_one_done", n_done - nd, 1);

      // reset mid-MEASURE
      ro_per = 4;
      repeat (10) @(negedge clk);
      start(100, k);
      repeat (S + 24) @(negedge clk);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("mid_rst_ro_en", ro_en_a, 0);
      chk("mid_rst_busy", busy_a, 0);
      chk("mid_rst_count", cnt_a, 0);
      chk("mid_rst_count8", cnt_b, 0);
      chk("mid_rst_ovf8", ovf_b, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      nd = n_done;
      repeat (200) @(negedge clk);
      chk("rst_no_done", n_done - nd, 0);
      start(100, k);
      wait_done("post_rst", 300, at);
      chk("post_rst_cycle", at - k + 1, 117);
      chk("post_rst_count", cnt_a, 25);
      repeat (3) @(negedge clk);

      // G=0 behaves as a one-cycle window
      ro_per = 2;
      repeat (10) @(negedge clk);
      start(0, k);
      wait_done("g0", 60, at);
      chk("g0_done_cycle", at - k + 1, S + 2);
      chk("g0_count_le1", (cnt_a <= 24'd1), 1);
      repeat (3) @(negedge clk);

      // edges only during SETTLE are not counted
      start(50, k);
      repeat (7) @(negedge clk);
      ro_per = 0;
      ro_lvl = 1'b0;
      wait_done("settle", 120, at);
      chk("settle_count", cnt_a, 0);
      chk("settle_ovf", ovf_a, 0);
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
